bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Sequencing controller that turns a 10-bit binary value into four decimal digits and drives them onto one shared 7-segment bus.
- Conversion is an iterative shift-add-3 (double dabble), started by a load/busy/done handshake.
- Digits are time-multiplexed across four active-low digit anodes by a prescaled refresh scanner.
- Sits between the switch/register front end and the board's multiplexed 4-digit display.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range >= 2.
- BLANK_LZ, 1, 1 = blank leading zeros (units digit never blanked); 0 = show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bin_in  in  10  binary value 0..1023.
- load  in  1  start request; sampled only in IDLE.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- bcd_out  out  16  committed digits {thousands, hundreds, tens, units}, 4 bits each.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[0] = units ... an[3] = thousands.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, busy = 0, done = 0, bcd_out = 0.
  - Prescaler = 0, digit index = 0, an = 4'b1110, seg = 7'h40 ("0").
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - If load = 1 at edge N, capture bin_in into a 26-bit shift register ({16'b0, bin_in}).
  - Clear the iteration counter, go to CONVERT, and set busy = 1 from edge N.
- CONVERT:
  - Edges N+1..N+10 each perform one iteration: every BCD nibble >= 5 gets +3, then the whole register shifts left 1.
  - After the 10th iteration, go to COMMIT.
- COMMIT:
  - At edge N+11, write the upper 16 bits to bcd_out and set done = 1 for exactly that cycle.
  - Clear busy at the same edge and return to IDLE.
  - Total latency: 11 cycles from load edge to done.
- load while busy is ignored and not queued.
  - load held high re-triggers on the first IDLE cycle, i.e. back-to-back conversions every 12 cycles.
- bcd_out holds its previous value for the whole conversion and never shows partial results.
- Maximum input 1023 gives bcd_out = 16'h1023. No saturation is needed; every nibble is always 0..9.
- Scanner:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments 0→1→2→3→0.
  - Scanner runs independently of the FSM, including during conversion.
- Anode output: an is one-hot-low at the index position, so exactly one bit is low at all times after reset.
- Segment output:
  - seg is a combinational decode of the registered index and bcd_out, so seg and an change in the same cycle.
  - Codes 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank = 7'h7F.
- Blanking (BLANK_LZ = 1):
  - Thousands blank if 0.
  - Hundreds blank if thousands and hundreds are 0.
  - Tens blank if thousands, hundreds and tens are 0.
  - Units always shown. The anode stays asserted; only seg is blanked.
- Reset mid-conversion: immediate return to reset values, bcd_out = 0, and no done pulse.

Test Plan:
1. Reset, then release with no load → an = 1110, seg = 7'h40, busy = 0, bcd_out = 0; with BLANK_LZ = 1, slots 1..3 show seg = 7'h7F.
2. bin_in = 10'd1023, load pulse at edge N → busy = 1 at N..N+10, done pulse at N+11, bcd_out = 16'h1023; slots read seg 79,40,24,30 (thousands..units).
3. bin_in = 10'd7, BLANK_LZ = 1 → bcd_out = 16'h0007; units seg = 7'h78, other three slots 7'h7F; with BLANK_LZ = 0, other slots show 7'h40.
4. Load 10'd512, then pulse load with 10'd99 at N+5 → 99 ignored, bcd_out = 16'h0512 at N+11; a later load of 99 gives 16'h0099.
5. REFRESH_DIV = 4 → an cycles 1110,1101,1011,0111 every 4 clocks, wraps to 1110, and continues unchanged during a conversion.
6. Assert rst_n low at N+6 of a conversion of 10'd300 → busy = 0 and bcd_out = 0 immediately (asynchronous), and no done pulse follows.

Source files
------------

// File: rtl/bcd_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_if
//   Handshake and result bundle between the register front end and the
//   BCD scan controller.
//
//   bin_in  : 10-bit binary value to convert (0..1023)
//   load    : start request, only honoured while the controller is idle
//   busy    : conversion in progress
//   done    : one-cycle pulse when bcd_out has just been updated
//   bcd_out : committed digits {thousands, hundreds, tens, units}
//
//   master : the front end (drives bin_in/load, observes status/result)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface bcd_scan_if;
  logic [9:0]  bin_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;

  modport master (
    output bin_in,
    output load,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  bin_in,
    input  load,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_scan_ctrl
//   Converts a 10-bit binary value to four BCD digits with an iterative
//   shift-add-3 (double dabble) and scans the committed digits onto a shared
//   active-low 7-segment bus with active-low digit anodes.
//
//   Parameters
//     REFRESH_DIV : clk cycles per digit slot (>= 2)
//     BLANK_LZ    : 1 = blank leading zeros (units always shown)
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : bcd_scan_if.slave (bin_in, load, busy, done, bcd_out)
//     seg   : {g,f,e,d,c,b,a}, active-low
//     an    : digit enables, active-low, an[0] = units .. an[3] = thousands
// ---------------------------------------------------------------------------
module bcd_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_scan_if.slave   bus,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [25:0]  shreg;
  logic [3:0]   iter_cnt;
  logic         done_q;
  logic [15:0]  bcd_q;

  logic [PW-1:0] pre_cnt;
  logic [1:0]    dig_idx;

  logic [3:0]   dig;
  logic         blank;
  logic         thous_z;
  logic         hund_z;
  logic         tens_z;

  // One double-dabble iteration: correct every BCD nibble that would
  // overflow past 9 on doubling, then shift the whole register left.
  function automatic logic [25:0] dd_step(input logic [25:0] r);
    logic [25:0] t;
    t = r;
    for (int i = 0; i < 4; i++) begin
      if (t[10 + 4*i +: 4] >= 4'd5)
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
    end
    return {t[24:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // ---- conversion FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = CONVERT;
      CONVERT: if (iter_cnt == 4'd9) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= 4'd0;
      done_q   <= 1'b0;
      bcd_q    <= 16'h0000;
    end else begin
      done_q <= (state == COMMIT);
      if (state == IDLE && bus.load)
        iter_cnt <= 4'd0;
      else if (state == CONVERT)
        iter_cnt <= iter_cnt + 4'd1;
      // bcd_q only moves at commit, so partial results are never visible.
      if (state == COMMIT)
        bcd_q <= shreg[25:10];
    end
  end

  // Working register carries data only; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.load)
      shreg <= {16'h0000, bus.bin_in};
    else if (state == CONVERT)
      shreg <= dd_step(shreg);
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

  // ---- refresh scanner ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (pre_cnt == PW'(REFRESH_DIV - 1)) begin
      pre_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign an = ~(4'b0001 << dig_idx);

  // ---- segment decode (combinational from registered index) ----
  assign thous_z = (bcd_q[15:12] == 4'd0);
  assign hund_z  = thous_z && (bcd_q[11:8] == 4'd0);
  assign tens_z  = hund_z && (bcd_q[7:4] == 4'd0);

  always_comb begin
    dig   = bcd_q[3:0];
    blank = 1'b0;
    case (dig_idx)
      2'd0: begin dig = bcd_q[3:0];   blank = 1'b0;    end
      2'd1: begin dig = bcd_q[7:4];   blank = tens_z;  end
      2'd2: begin dig = bcd_q[11:8];  blank = hund_z;  end
      2'd3: begin dig = bcd_q[15:12]; blank = thous_z; end
      default: begin dig = bcd_q[3:0]; blank = 1'b0; end
    endcase
    seg = (BLANK_LZ && blank) ? 7'h7F : seg7(dig);
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
module tb_bcd_scan_ctrl;
  logic clk;
  logic rst_n;
  logic [6:0] seg, seg0;
  logic [3:0] an, an0;
  int total = 0;
  int bad = 0;

  bcd_scan_if u_if ();
  bcd_scan_if u_if0 ();

  assign u_if0.bin_in = u_if.bin_in;
  assign u_if0.load   = u_if.load;

  bcd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave), .seg(seg), .an(an)
  );

  bcd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0.slave), .seg(seg0), .an(an0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; release lands mid-cycle.
  task automatic do_reset;
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    while (an !== target && n < 40) begin
      tick();
      n++;
    end
    chk("an_sync", {28'd0, an}, {28'd0, target});
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] a,
                          input logic [6:0] e1, input logic [6:0] e0);
    wait_an(a);
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e1});
    chk({tag, "_seg0"}, {25'd0, seg0}, {25'd0, e0});
  endtask

  task automatic run_conv(input logic [9:0] v, input logic [15:0] exp,
                          input logic [15:0] prev);
    u_if.bin_in = v;
    u_if.load   = 1'b1;
    tick();                               // edge N
    u_if.load   = 1'b0;
    chk("busy_N", {31'd0, u_if.busy}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("busy_run", {31'd0, u_if.busy}, 32'd1);
      chk("done_early", {31'd0, u_if.done}, 32'd0);
      if (i == 5) chk("bcd_hold", {16'd0, u_if.bcd_out}, {16'd0, prev});
    end
    tick();                               // edge N+11
    chk("done_pulse", {31'd0, u_if.done}, 32'd1);
    chk("busy_clr", {31'd0, u_if.busy}, 32'd0);
    chk("bcd_out", {16'd0, u_if.bcd_out}, {16'd0, exp});
    tick();
    chk("done_one", {31'd0, u_if.done}, 32'd0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    u_if.load = 1'b0;
    u_if.bin_in = 10'd0;

    // Reset values (checked while reset is held)
    #3;
    chk("rst_an", {28'd0, an}, 32'hE);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_done", {31'd0, u_if.done}, 32'd0);
    chk("rst_bcd", {16'd0, u_if.bcd_out}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();

    // Test 1: idle display of zero
    chk_slot("z_t", 4'b1101, 7'h7F, 7'h40);
    chk_slot("z_h", 4'b1011, 7'h7F, 7'h40);
    chk_slot("z_k", 4'b0111, 7'h7F, 7'h40);
    chk_slot("z_u", 4'b1110, 7'h40, 7'h40);

    // Test 5: scanner cadence from reset release, unaffected by a conversion
    do_reset();
    u_if.bin_in = 10'd42;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("scan_an", {28'd0, an}, {28'd0, ~(4'b0001 << ((c / 4) % 4))});
      if (c == 5) u_if.load = 1'b1;      // sampled at edge 6
      if (c == 6) u_if.load = 1'b0;
      if (c == 17) begin
        chk("scan_done", {31'd0, u_if.done}, 32'd1);
        chk("scan_bcd", {16'd0, u_if.bcd_out}, 32'h0042);
      end
    end

    // Test 2: maximum input
    run_conv(10'd1023, 16'h1023, 16'h0042);
    chk_slot("m_k", 4'b0111, 7'h79, 7'h79);
    chk_slot("m_u", 4'b1110, 7'h30, 7'h30);
    chk_slot("m_t", 4'b1101, 7'h24, 7'h24);
    chk_slot("m_h", 4'b1011, 7'h40, 7'h40);

    // Test 3: single digit, blanking vs. no blanking
    run_conv(10'd7, 16'h0007, 16'h1023);
    chk("bcd0_7", {16'd0, u_if0.bcd_out}, 32'h0007);
    chk_slot("s_u", 4'b1110, 7'h78, 7'h78);
    chk_slot("s_t", 4'b1101, 7'h7F, 7'h40);
    chk_slot("s_h", 4'b1011, 7'h7F, 7'h40);
    chk_slot("s_k", 4'b0111, 7'h7F, 7'h40);

    // Test 4: load during busy is ignored
    u_if.bin_in = 10'd512;
    u_if.load   = 1'b1;
    tick();                               // edge N
    u_if.load   = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin
        u_if.bin_in = 10'd99;
        u_if.load   = 1'b1;               // sampled at edge N+5
      end
      tick();
      u_if.load = 1'b0;
      chk("ign_busy", {31'd0, u_if.busy}, 32'd1);
    end
    tick();                               // edge N+11
    chk("ign_done", {31'd0, u_if.done}, 32'd1);
    chk("ign_bcd", {16'd0, u_if.bcd_out}, 32'h0512);
    tick();
    chk("ign_idle", {31'd0, u_if.busy}, 32'd0);
    run_conv(10'd99, 16'h0099, 16'h0512);
    chk_slot("n_t", 4'b1101, 7'h10, 7'h10);
    chk_slot("n_h", 4'b1011, 7'h7F, 7'h40);

    // Test 6: asynchronous reset mid-conversion
    u_if.bin_in = 10'd300;
    u_if.load   = 1'b1;
    tick();                               // edge N
    u_if.load   = 1'b0;
    for (int i = 1; i <= 6; i++) tick();  // edge N+6
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, u_if.busy}, 32'd0);
    chk("ar_bcd", {16'd0, u_if.bcd_out}, 32'd0);
    chk("ar_an", {28'd0, an}, 32'hE);
    chk("ar_seg", {25'd0, seg}, 32'h40);
    #3;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (u_if.done === 1'b1) dcnt++;
    end
    chk("ar_nodone", dcnt, 0);
    chk("ar_idle", {31'd0, u_if.busy}, 32'd0);
    chk("ar_bcd2", {16'd0, u_if.bcd_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
